// File: rtl/mem_responder_if.sv
// mem_responder_if
// Bundles the core's single-port memory bus with the outbound TX stream.
//   MemWrite  : write strobe from the core
//   Adr       : byte address from the core (bits [1:0] ignored)
//   WriteData : write data from the core
//   ReadData  : combinational read data for the current Adr
//   tx_data   : TX FIFO head word
//   tx_valid  : TX FIFO non-empty
//   tx_ready  : stream sink accepts the head word this cycle
// The master modport is the core/sink side; the slave modport is the responder.
interface mem_responder_if;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output MemWrite, Adr, WriteData, tx_ready,
    input  ReadData, tx_data, tx_valid
  );

  modport slave (
    input  MemWrite, Adr, WriteData, tx_ready,
    output ReadData, tx_data, tx_valid
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
// Target-side memory for the multicycle ARM core: a unified RAM below
// 0x8000_0000 and a small I/O window above it holding a TX FIFO that
// drains to a valid/ready stream, a STATUS register and a cycle counter.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low; clears all non-RAM state
//   bus   : mem_responder_if.slave (core bus + TX stream)
// I/O map (Adr[4:2]): 0 TXDATA (write pushes, reads 0),
//   1 STATUS {24'b0, count[3:0], 1'b0, OVF, EMPTY, FULL},
//   2 CYCLES (free-running, writable), 3..7 read 0 / writes ignored.
module mem_responder #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = FIFO_DEPTH[PW:0];

  logic [31:0] mem  [MEM_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          ovf;
  logic [31:0]   cycles;

  logic          is_io;
  logic [AW-1:0] ram_idx;
  logic [2:0]    io_idx;
  logic          ram_we;
  logic          tx_push;
  logic          status_we;
  logic          cycles_we;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;
  logic          ovf_clr;
  logic [3:0]    count_field;
  logic [31:0]   status;
  logic [31:0]   read_data;

  // Upper RAM address bits alias and the byte offset is ignored.
  logic unused_adr;
  assign unused_adr = ^{bus.Adr[30:AW+2], bus.Adr[1:0]};

  assign is_io   = bus.Adr[31];
  assign ram_idx = bus.Adr[AW+1:2];
  assign io_idx  = bus.Adr[4:2];

  assign ram_we    = bus.MemWrite & ~is_io;
  assign tx_push   = bus.MemWrite & is_io & (io_idx == 3'd0);
  assign status_we = bus.MemWrite & is_io & (io_idx == 3'd1);
  assign cycles_we = bus.MemWrite & is_io & (io_idx == 3'd2);

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign pop   = ~empty & bus.tx_ready;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok = tx_push & (~full | pop);
  assign ovf_set = tx_push & full & ~pop;
  assign ovf_clr = status_we & bus.WriteData[2];

  assign count_field = 4'(count);
  assign status      = {24'b0, count_field, 1'b0, ovf, empty, full};

  assign bus.tx_valid = ~empty;
  assign bus.tx_data  = fifo[rd_ptr];
  assign bus.ReadData = read_data;

  // Zero-latency read mux for RAM and the I/O window.
  always_comb begin
    read_data = '0;
    if (!is_io) begin
      read_data = mem[ram_idx];
    end else begin
      case (io_idx)
        3'd1:    read_data = status;
        3'd2:    read_data = cycles;
        default: read_data = '0;
      endcase
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= bus.WriteData;
    end
  end

  // FIFO storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo[wr_ptr] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky overflow; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // A load replaces the increment for that edge, so the loaded value is
  // visible for one full cycle before counting resumes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else if (cycles_we) begin
      cycles <= bus.WriteData;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

endmodule
